// File: rtl/pc_gen.sv
// Fetch-stage program counter: boot hold, trap/redirect steering, halt/resume
// control and a valid/ready request toward instruction memory.
module pc_gen #(
   parameter int                      DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]   RESET_VECTOR = '0,
   parameter int                      INC          = 4,
   parameter int                      BOOT_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  fetch_ready,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  trap_valid,
   input  logic [DATA_WIDTH-1:0] trap_vector,
   input  logic                  halt_req,
   input  logic                  resume_req,
   output logic [DATA_WIDTH-1:0] pc_out,
   output logic [DATA_WIDTH-1:0] pc_plus,
   output logic                  fetch_valid,
   output logic                  halted,
   output logic                  misalign_err
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam int CW      = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int BC_LAST = (BOOT_CYCLES > 0) ? BOOT_CYCLES - 1 : 0;
   localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(INC);
   localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(INC - 1);

   state_t                  state;
   logic [CW-1:0]           boot_cnt;
   logic                    boot_done;
   logic [DATA_WIDTH-1:0]   redirect_aligned;
   logic                    redirect_odd;

   assign boot_done        = (BOOT_CYCLES <= 1) || (boot_cnt == CW'(BC_LAST));
   assign redirect_aligned = redirect_pc & ~LOW_MASK;
   assign redirect_odd     = |(redirect_pc & LOW_MASK);
   assign pc_plus          = pc_out + STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         boot_cnt     <= '0;
         pc_out       <= RESET_VECTOR;
         fetch_valid  <= 1'b0;
         halted       <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         unique case (state)
            BOOT: begin
               if (boot_done) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + CW'(1);
               end
            end
            RUN: begin
               // trap beats redirect; both beat halt and stall for the PC value
               if (trap_valid)
                  pc_out <= trap_vector;
               else if (redirect_valid) begin
                  pc_out       <= redirect_aligned;
                  misalign_err <= redirect_odd;
               end else if (!halt_req && en && fetch_ready)
                  pc_out <= pc_out + STEP;
               if (halt_req) begin
                  state       <= HALT;
                  fetch_valid <= 1'b0;
                  halted      <= 1'b1;
               end
            end
            HALT: begin
               if (trap_valid)
                  pc_out <= trap_vector;
               else if (redirect_valid) begin
                  pc_out       <= redirect_aligned;
                  misalign_err <= redirect_odd;
               end
               // a trap wakes the core; resume wins over a concurrent halt_req
               if (trap_valid || resume_req) begin
                  state       <= RUN;
                  fetch_valid <= 1'b1;
                  halted      <= 1'b0;
               end
            end
            default: begin
               state       <= BOOT;
               boot_cnt    <= '0;
               fetch_valid <= 1'b0;
               halted      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the fetch-stage PC register.
- Adds on top of the basic stall-enable PC:
  - configurable width, reset vector and instruction step;
  - a post-reset boot hold;
  - prioritised trap/branch redirect that overrides stall;
  - a halt/resume state machine;
  - a valid/ready handshake toward instruction memory.
- Sits at the head of the IF stage; the hazard unit drives en, EX drives redirects, the CSR/trap logic drives traps.

Parameters:
- DATA_WIDTH, 32: PC width in bits.
- RESET_VECTOR, 0: PC value loaded on reset.
- INC, 4: sequential step in bytes; power of two, 2 or 4.
- BOOT_CYCLES, 2: cycles fetch_valid stays low after reset release; 0 allowed.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  hazard enable; 0 = stall sequential advance.
- fetch_ready  in  1  instruction memory accepts pc_out this cycle.
- redirect_valid  in  1  branch/jump taken (flush).
- redirect_pc  in  DATA_WIDTH  branch/jump target.
- trap_valid  in  1  trap/exception taken.
- trap_vector  in  DATA_WIDTH  trap handler address.
- halt_req  in  1  request halt (debug/WFI).
- resume_req  in  1  request resume from halt.
- pc_out  out  DATA_WIDTH  current fetch PC.
- pc_plus  out  DATA_WIDTH  pc_out + INC, combinational, wraps modulo 2^DATA_WIDTH.
- fetch_valid  out  1  pc_out is a valid fetch request.
- halted  out  1  state == HALT.
- misalign_err  out  1  one-cycle pulse: misaligned redirect target.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock.
  - While asserted: pc_out=RESET_VECTOR, state=BOOT, boot counter=0, fetch_valid=0, halted=0, misalign_err=0.
  - Reset mid-operation aborts everything immediately: any pending redirect or halt is discarded.
- States: BOOT, RUN, HALT. All outputs are registered except pc_plus; fetch_valid = (state==RUN); halted = (state==HALT).
- BOOT:
  - Counter increments each cycle; move to RUN on the edge where counter == BOOT_CYCLES-1.
  - BOOT_CYCLES=0: move to RUN on the first edge after reset release.
  - PC holds. Redirect and trap are ignored in BOOT.
- Per-edge priority in RUN, highest first:
  1. trap_valid: pc <= trap_vector; the trap target is not checked for alignment.
  2. redirect_valid: pc <= redirect_pc with its low log2(INC) bits cleared.
  3. halt_req: pc holds; state -> HALT.
  4. en && fetch_ready: pc <= pc + INC, wrapping modulo 2^DATA_WIDTH.
  5. Otherwise pc holds.
- Trap and redirect override stall: they apply regardless of en and fetch_ready.
- If trap or redirect coincides with halt_req in RUN, the PC loads the target and state still -> HALT.
- Handshake: a fetch is transferred when fetch_valid && fetch_ready. pc_out stays stable while fetch_valid=1 and fetch_ready=0, unless a trap or redirect occurs.
- HALT:
  - PC holds.
  - resume_req -> RUN next edge; resume wins over a simultaneous halt_req.
  - trap_valid -> pc <= trap_vector and state -> RUN (wake on trap).
  - redirect_valid loads pc with low bits cleared and state stays HALT.
- misalign_err: asserted for one cycle on the edge following acceptance of a redirect whose low log2(INC) bits are non-zero.
  - Not raised when a trap wins that cycle.
  - Not raised in BOOT.
- Latency: every PC update is visible on pc_out one clock after the causing edge's inputs are sampled.

Test Plan:
- Reset, BOOT_CYCLES=2, RESET_VECTOR=0x0, en=1, fetch_ready=1 -> fetch_valid=0 for 2 cycles after release, then pc_out=0x0, 0x4, 0x8 on successive cycles; pc_plus=pc_out+4.
- Stall and handshake:
  - en=0 for 3 cycles at pc=0x10 -> pc_out holds 0x10.
  - fetch_ready=0 at pc=0x14 -> holds.
  - Both high -> 0x18.
- Priority and misalignment:
  - redirect_valid with redirect_pc=0x200 while en=0 -> pc_out=0x200 next cycle.
  - Same cycle as trap_valid with trap_vector=0x80 -> pc_out=0x80, misalign_err stays 0.
  - redirect_pc=0x203 alone -> pc_out=0x200 and misalign_err pulses one cycle.
- Halt and resume:
  - halt_req at pc=0x40 -> halted=1, fetch_valid=0, pc_out holds 0x40 for 5 cycles.
  - resume_req -> RUN, next fetch 0x40 then 0x44.
  - Separately, trap in HALT with vector 0x100 -> halted=0, pc_out=0x100.
- Wrap and width: DATA_WIDTH=16, INC=2, redirect to 0xFFFE -> next pc_out=0x0000, pc_plus=0x0002.
- Asynchronous reset mid-run at pc=0x1234, asserted between clock edges -> pc_out=RESET_VECTOR and fetch_valid=0 immediately, without waiting for a clock edge; BOOT sequence repeats after release.
